wb_regfile: RTL and testbench

- Write-back end of the MEM/WB pipeline register. Consumes its registered outputs: load data, ALU result, link address, MemtoReg, regwrite, destination rd.
- Selects the write-back value and commits it into a 32 x 64-bit integer register file.
- Serves the ID stage's two combinational read ports with same-cycle write-to-read bypass.
- Also provides a commit counter and a registered debug read port.

---
 rtl/wb_regfile.sv | 110 +++++++++++
 tb/tb_wb_regfile.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Write-back stage: selects the result to commit, owns the 32 x XLEN integer register file,
// serves the two ID read ports with write-through bypass, counts commits and exposes a debug read port.
module wb_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] wb_rd_data,
    input  logic [XLEN-1:0] wb_alu_data,
    input  logic [XLEN-1:0] wb_link_data,
    input  logic            wb_memtoreg,
    input  logic            wb_link,
    input  logic            wb_regwrite,
    input  logic [AW-1:0]   wb_rd,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] wb_data,
    output logic [63:0]     commit_count,
    input  logic [AW-1:0]   dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [63:0]     commit_q;
    logic [63:0]     commit_d;
    logic [XLEN-1:0] dbg_q;
    logic [XLEN-1:0] dbg_d;
    logic            wr_en;

    // Link has priority over memtoreg (jal/jalr never load).
    always_comb begin
        wb_data = wb_alu_data;
        if (wb_link) begin
            wb_data = wb_link_data;
        end else if (wb_memtoreg) begin
            wb_data = wb_rd_data;
        end
    end

    assign wr_en = wb_regwrite && (wb_rd != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign regs_q[gi] = '0;
            end else begin : g_gpr
                always_ff @(posedge clk) begin
                    if (rst) begin
                        regs_q[gi] <= '0;
                    end else if (wr_en && (wb_rd == AW'(gi))) begin
                        regs_q[gi] <= wb_data;
                    end
                end
            end
        end
    endgenerate

    // Bypass matches on wb_regwrite alone; the addr==0 guard keeps x0 reading zero.
    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wb_regwrite && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wb_regwrite && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end
    end

    always_comb begin
        commit_d = commit_q;
        if (wr_en) begin
            commit_d = commit_q + 64'd1;
        end
    end

    // Debug read sees the array before this edge's write: no bypass by design.
    always_comb begin
        dbg_d = regs_q[dbg_addr];
        if (dbg_addr == '0) begin
            dbg_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_q <= '0;
            dbg_q    <= '0;
        end else begin
            commit_q <= commit_d;
            dbg_q    <= dbg_d;
        end
    end

    assign commit_count = commit_q;
    assign dbg_data     = dbg_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Randomized scoreboard bench for wb_regfile: the driver predicts each cycle's outputs from an
// array model of the register file; a separate monitor pops the predictions and compares.
module tb_wb_regfile;
    timeunit 1ns;
    timeprecision 1ps;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] wb_rd_data = '0, wb_alu_data = '0, wb_link_data = '0;
    logic        wb_memtoreg = 1'b0, wb_link = 1'b0, wb_regwrite = 1'b0;
    logic [4:0]  wb_rd = '0, rs1_addr = '0, rs2_addr = '0, dbg_addr = '0;
    logic [63:0] rs1_data, rs2_data, wb_data, commit_count, dbg_data;

    wb_regfile dut (
        .clk(clk), .rst(rst),
        .wb_rd_data(wb_rd_data), .wb_alu_data(wb_alu_data), .wb_link_data(wb_link_data),
        .wb_memtoreg(wb_memtoreg), .wb_link(wb_link), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .wb_data(wb_data), .commit_count(commit_count), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_comb;
        logic [63:0] e_rs1, e_rs2, e_wb, e_dbg, e_cnt;
        logic [4:0]  rd, a1, a2, da;
        bit          we, r;
    } item_t;

    item_t       sb_q[$];
    logic [63:0] m_regs [32];
    logic [63:0] m_cnt;
    bit          m_valid = 1'b0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One transaction per call: inputs applied just after a rising edge, prediction queued.
    task automatic drive(input bit r, input bit we, input bit lnk, input bit m2r,
                         input logic [4:0] rd, input logic [63:0] ad, input logic [63:0] md,
                         input logic [63:0] ld, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] da, input bit frc);
        item_t       it;
        logic [63:0] sel;
        @(posedge clk);
        #1;
        rst = r; wb_regwrite = we; wb_link = lnk; wb_memtoreg = m2r; wb_rd = rd;
        wb_alu_data = ad; wb_rd_data = md; wb_link_data = ld;
        rs1_addr = a1; rs2_addr = a2; dbg_addr = da;
        if (frc) begin
            #2;
            force dut.commit_q = 64'hFFFF_FFFF_FFFF_FFFF;
            #1;
            release dut.commit_q;
            m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        sel = lnk ? ld : (m2r ? md : ad);
        it.chk_comb = m_valid;
        it.e_wb  = sel;
        it.e_rs1 = (a1 == 0) ? 64'd0 : ((we && rd == a1) ? sel : m_regs[a1]);
        it.e_rs2 = (a2 == 0) ? 64'd0 : ((we && rd == a2) ? sel : m_regs[a2]);
        it.e_dbg = r ? 64'd0 : m_regs[da];
        it.rd = rd; it.a1 = a1; it.a2 = a2; it.da = da; it.we = we; it.r = r;
        if (r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cnt   = '0;
            m_valid = 1'b1;
        end else if (we && rd != 0) begin
            m_regs[rd] = sel;
            m_cnt      = m_cnt + 1;
        end
        it.e_cnt = m_cnt;
        sb_q.push_back(it);
    endtask

    task automatic rd_only(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] da);
        drive(0, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0, a1, a2, da, 0);
    endtask

    // Monitor: combinational outputs mid-cycle, registered outputs just after the edge.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                if (it.chk_comb) begin
                    chk($sformatf("rs1[x%0d] we=%0d rd=%0d", it.a1, it.we, it.rd), rs1_data, it.e_rs1);
                    chk($sformatf("rs2[x%0d] we=%0d rd=%0d", it.a2, it.we, it.rd), rs2_data, it.e_rs2);
                end
                chk("wb_data", wb_data, it.e_wb);
                @(posedge clk);
                #1;
                chk($sformatf("dbg[x%0d] rst=%0d", it.da, it.r), dbg_data, it.e_dbg);
                chk($sformatf("commit_count rst=%0d", it.r), commit_count, it.e_cnt);
                $display("txn rst=%0d we=%0d rd=%0d rs1=%0d rs2=%0d dbg=%0d wb=%h cnt=%0d",
                         it.r, it.we, it.rd, it.a1, it.a2, it.da, it.e_wb, it.e_cnt);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin
        int drained;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = '0;

        drive(1, 0, 0, 0, 5'd0, 64'd0, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 0);
        rd_only(5'd5, 5'd31, 5'd7);
        // write-back select variants on x3
        drive(0, 1, 0, 0, 5'd3, 64'h1111, 64'h2222, 64'h3333, 5'd3, 5'd0, 5'd3, 0);
        drive(0, 1, 0, 1, 5'd3, 64'h1111, 64'h2222, 64'h3333, 5'd0, 5'd3, 5'd3, 0);
        drive(0, 1, 1, 1, 5'd3, 64'h1111, 64'h2222, 64'h3333, 5'd3, 5'd3, 5'd3, 0);
        rd_only(5'd3, 5'd3, 5'd3);
        // bypass on both ports, debug sees pre-write value
        drive(0, 1, 0, 0, 5'd9, 64'hAA, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 0);
        drive(0, 1, 0, 0, 5'd9, 64'hDEAD_BEEF, 64'd0, 64'd0, 5'd9, 5'd9, 5'd9, 0);
        rd_only(5'd9, 5'd9, 5'd9);
        // x0 write is dropped
        drive(0, 1, 0, 0, 5'd0, 64'hFFFF, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 0);
        rd_only(5'd0, 5'd0, 5'd0);
        // bubble leaves x4 alone
        drive(0, 0, 0, 0, 5'd4, 64'h55, 64'h55, 64'h55, 5'd4, 5'd4, 5'd4, 0);
        rd_only(5'd4, 5'd4, 5'd4);
        // counter wrap
        drive(0, 1, 0, 0, 5'd6, 64'h66, 64'd0, 64'd0, 5'd6, 5'd0, 5'd6, 1);
        rd_only(5'd6, 5'd6, 5'd6);
        // reset discards a concurrent write
        drive(0, 1, 0, 0, 5'd12, 64'h12, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 0);
        drive(1, 1, 0, 0, 5'd12, 64'h77, 64'd0, 64'd0, 5'd0, 5'd0, 5'd0, 0);
        rd_only(5'd12, 5'd12, 5'd12);

        for (int n = 0; n < 400; n++) begin
            logic [4:0] rd, a1, a2, da;
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            da = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            drive($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, rd,
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  a1, a2, da, 0);
        end

        drained = 0;
        for (int c = 0; c < 20 && !drained; c++) begin
            @(posedge clk);
            if (sb_q.size() == 0) drained = 1;
        end
        total++;
        if (!drained) begin
            bad++;
            $display("FAIL drain: %0d items left, required 0", sb_q.size());
        end
        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
